cve2_csr_access_ctrl: RTL and testbench
=======================================

Name: cve2_csr_access_ctrl

Overview:
- Sequences read/write/set/clear accesses from several requesters onto a bank of single-cycle CSR primitives.
- Requesters are, for example, core CSR unit and debug module.
- Arbitrates round-robin, performs read-modify-write over a fixed multi-cycle sequence and returns the old value.
- Monitors each primitive's shadow-copy read error and raises a sticky integrity alert.

Parameters:
- NumReq, 2, number of requesters (>=2).
- NumCsr, 8, number of CSR primitives in the bank.
- Width, 32, CSR data width.
- IdxW, $clog2(NumCsr), CSR index width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NumReq  request valid per requester.
- req_ready_o  out  NumReq  request accepted (one-hot, one cycle).
- req_op_i  in  NumReq x 2  csr_op_e per requester.
- req_idx_i  in  NumReq x IdxW  target CSR index.
- req_wdata_i  in  NumReq x Width  write/mask data.
- rsp_valid_o  out  NumReq  response valid, one-hot to the granted requester.
- rsp_ready_i  in  NumReq  response consumed.
- rsp_rdata_o  out  Width  pre-access CSR value.
- rsp_err_o  out  1  access error (bad index, integrity, lock).
- csr_wr_en_o  out  NumCsr  write enable per primitive.
- csr_wr_data_o  out  Width  shared write data.
- csr_rd_data_i  in  NumCsr x Width  primitive read data.
- csr_rd_error_i  in  NumCsr  primitive shadow mismatch.
- csr_lock_i  in  NumCsr  per-CSR write lock; used only with the optional feature.
- integrity_alert_o  out  1  sticky integrity alert.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM IDLE.
  - Round-robin pointer at requester 0.
  - Alert cleared.
  - Async reset mid-sequence deasserts csr_wr_en_o immediately; any pending response is dropped.
- IDLE:
  - Round-robin grant among req_valid_i, starting at the pointer.
  - req_ready_o[g]=1 in the same cycle.
  - Latch op, idx, wdata and g.
  - Pointer becomes g+1 mod NumReq.
  - Go to READ.
- READ:
  - Sample csr_rd_data_i[idx] into old_q.
  - err = (idx >= NumCsr) | csr_rd_error_i[idx].
  - new = wdata (WRITE), old|wdata (SET), old&~wdata (CLEAR).
  - Go to WRITE unless err, op==READ, or (SET/CLEAR with wdata==0); otherwise go to RESP.
  - Out-of-range idx reads old_q = 0.
- WRITE:
  - csr_wr_en_o[idx]=1 and csr_wr_data_o=new for exactly one cycle.
  - Go to RESP.
  - csr_wr_data_o = 0 whenever no write is enabled.
- RESP:
  - rsp_valid_o[id]=1 with rsp_rdata_o=old_q and rsp_err_o=err, held until rsp_ready_i[id].
  - Then go to IDLE; a new grant is possible in the next cycle.
  - rsp_rdata_o and rsp_err_o = 0 outside RESP.
- Latency from acceptance to rsp_valid: 2 cycles without a write, 3 cycles with a write.
- Only one access is in flight; req_ready_o is 0 outside IDLE.
- Requesters keep request fields stable while valid and unaccepted.
- integrity_alert_o:
  - Set on the cycle after READ samples csr_rd_error_i[idx]=1.
  - Cleared only by reset.
  - Errors on non-selected CSRs are ignored.

Optional Feature:
- Macro: CVE2_CSR_ACCESS_LOCK_EN.
- Defined: in READ, a WRITE/SET/CLEAR to an idx with csr_lock_i[idx]=1 sets err and skips WRITE. READ ops to a locked idx are unaffected.
- Undefined: csr_lock_i is ignored and lock never causes err.

Decomposition:
- Package cve2_csr_access_pkg holds:
  - csr_op_e: 2 bits, CSR_OP_READ=0, CSR_OP_WRITE=1, CSR_OP_SET=2, CSR_OP_CLEAR=3.
  - ctrl_state_e: IDLE, READ, WRITE, RESP.
- Sub-module cve2_csr_rr_arb: NumReq round-robin arbiter taking request and pointer, returning a one-hot grant and an index.

Test Plan:
- CSR3=0x0000_00F0; req0 SET idx3 wdata 0x0F -> rsp_rdata 0xF0, err 0; wr_en[3] once with 0xFF; rsp_valid 3 cycles after accept.
- req0 and req1 both valid in IDLE after reset -> req0 granted first, then req1; alternation continues over 4 back-to-back accesses.
- CLEAR idx2 wdata 0 -> no csr_wr_en pulse; rsp after 2 cycles with old value.
- idx 9 with NumCsr=8, WRITE -> err 1, rdata 0, no write.
- csr_rd_error_i[5]=1 on READ of idx5 -> err 1, no write, integrity_alert_o=1 until reset.
- rsp_ready_i held 0 for 5 cycles, then reset asserted mid-WRITE -> wr_en drops immediately, all outputs 0; with CVE2_CSR_ACCESS_LOCK_EN defined, WRITE to locked idx1 -> err 1, no write.

Source files
------------

// File: rtl/cve2_csr_access_pkg.sv
// Shared types for the CSR access controller.
//   csr_op_e     : access kind carried on each requester's op field.
//   ctrl_state_e : controller sequence IDLE -> READ -> [WRITE] -> RESP.
package cve2_csr_access_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } ctrl_state_e;

endpackage

// File: rtl/cve2_csr_rr_arb.sv
// Round-robin arbiter: the search starts at ptr_i and wraps around.
// Ports:
//   req_i   : request vector, one bit per requester
//   ptr_i   : highest-priority requester for this cycle
//   gnt_o   : one-hot grant (all zero when no request)
//   idx_o   : binary index of the granted requester
//   valid_o : at least one request is present
module cve2_csr_rr_arb #(
  parameter int NumReq = 2,
  parameter int PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [PtrW-1:0]   idx_o,
  output logic              valid_o
);

  always_comb begin
    logic [PtrW-1:0] cand;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = PtrW'((32'(ptr_i) + i) % NumReq);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/cve2_csr_access_ctrl.sv
// CSR access controller: arbitrates several requesters round-robin onto a
// bank of single-cycle CSR primitives, performs read / write / set / clear
// as a read-modify-write sequence and returns the pre-access value.
// A shadow-copy read error on the selected CSR raises a sticky alert.
//
// Optional feature: define CVE2_CSR_ACCESS_LOCK_EN to make csr_lock_i block
// WRITE/SET/CLEAR (error, no write). Otherwise csr_lock_i is ignored.
//
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   req_valid_i/ready_o  : per-requester request handshake (ready one-hot)
//   req_op/idx/wdata_i   : per-requester op, CSR index, write/mask data
//   rsp_valid_o/ready_i  : per-requester response handshake
//   rsp_rdata_o, rsp_err_o : pre-access value and error flag
//   csr_wr_en_o, csr_wr_data_o : primitive write strobe and shared data
//   csr_rd_data_i, csr_rd_error_i : primitive read data and shadow mismatch
//   csr_lock_i           : per-CSR write lock (optional feature only)
//   integrity_alert_o    : sticky integrity alert
module cve2_csr_access_ctrl
  import cve2_csr_access_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int NumCsr = 8,
  parameter int Width  = 32,
  parameter int IdxW   = $clog2(NumCsr)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq-1:0][1:0]         req_op_i,
  input  logic [NumReq-1:0][IdxW-1:0]    req_idx_i,
  input  logic [NumReq-1:0][Width-1:0]   req_wdata_i,
  output logic [NumReq-1:0]              rsp_valid_o,
  input  logic [NumReq-1:0]              rsp_ready_i,
  output logic [Width-1:0]               rsp_rdata_o,
  output logic                           rsp_err_o,
  output logic [NumCsr-1:0]              csr_wr_en_o,
  output logic [Width-1:0]               csr_wr_data_o,
  input  logic [NumCsr-1:0][Width-1:0]   csr_rd_data_i,
  input  logic [NumCsr-1:0]              csr_rd_error_i,
  input  logic [NumCsr-1:0]              csr_lock_i,
  output logic                           integrity_alert_o
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  ctrl_state_e       state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_next, id_q;
  csr_op_e           op_q;
  logic [IdxW-1:0]   idx_q;
  logic [Width-1:0]  wdata_q, old_q, new_q;
  logic              err_q, alert_q;

  logic [NumReq-1:0] gnt;
  logic [PtrW-1:0]   gnt_idx;
  logic              gnt_valid;
  logic              accept;

  logic              in_range;
  logic [Width-1:0]  rd_sel, new_d;
  logic              rd_err_sel, lock_err, err_d, skip_write;

  cve2_csr_rr_arb #(
    .NumReq (NumReq),
    .PtrW   (PtrW)
  ) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign ptr_next = (32'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + PtrW'(1);

  // Selected primitive; an out-of-range index selects nothing, so the
  // sampled old value is zero and no shadow error is seen.
  always_comb begin
    in_range   = (32'(idx_q) < 32'(NumCsr));
    rd_sel     = '0;
    rd_err_sel = 1'b0;
    for (int unsigned i = 0; i < NumCsr; i++) begin
      if (32'(idx_q) == i) begin
        rd_sel     = csr_rd_data_i[i];
        rd_err_sel = csr_rd_error_i[i];
      end
    end
  end

`ifdef CVE2_CSR_ACCESS_LOCK_EN
  always_comb begin
    lock_err = 1'b0;
    for (int unsigned i = 0; i < NumCsr; i++) begin
      if (32'(idx_q) == i && op_q != CSR_OP_READ) lock_err = csr_lock_i[i];
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^csr_lock_i;
  assign lock_err    = 1'b0;
`endif

  always_comb begin
    unique case (op_q)
      CSR_OP_WRITE: new_d = wdata_q;
      CSR_OP_SET:   new_d = rd_sel | wdata_q;
      CSR_OP_CLEAR: new_d = rd_sel & ~wdata_q;
      default:      new_d = rd_sel;
    endcase
    err_d      = ~in_range | rd_err_sel | lock_err;
    // A set/clear with an empty mask cannot change the CSR, so skip it.
    skip_write = err_d | (op_q == CSR_OP_READ) |
                 (((op_q == CSR_OP_SET) || (op_q == CSR_OP_CLEAR)) && (wdata_q == '0));
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    req_ready_o   = '0;
    rsp_valid_o   = '0;
    rsp_rdata_o   = '0;
    rsp_err_o     = 1'b0;
    csr_wr_en_o   = '0;
    csr_wr_data_o = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          accept      = 1'b1;
          req_ready_o = gnt;
          state_d     = READ;
        end
      end
      READ: begin
        state_d = skip_write ? RESP : WRITE;
      end
      WRITE: begin
        for (int unsigned i = 0; i < NumCsr; i++) begin
          if (32'(idx_q) == i) csr_wr_en_o[i] = 1'b1;
        end
        csr_wr_data_o = new_q;
        state_d       = RESP;
      end
      RESP: begin
        rsp_valid_o[id_q] = 1'b1;
        rsp_rdata_o       = old_q;
        rsp_err_o         = err_q;
        if (rsp_ready_i[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= CSR_OP_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      new_q   <= '0;
      err_q   <= 1'b0;
      alert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q   <= ptr_next;
        id_q    <= gnt_idx;
        op_q    <= csr_op_e'(req_op_i[gnt_idx]);
        idx_q   <= req_idx_i[gnt_idx];
        wdata_q <= req_wdata_i[gnt_idx];
      end
      if (state_q == READ) begin
        old_q <= rd_sel;
        new_q <= new_d;
        err_q <= err_d;
        if (in_range && rd_err_sel) alert_q <= 1'b1;
      end
    end
  end

  assign integrity_alert_o = alert_q;

endmodule

// File: tb/tb_cve2_csr_access_ctrl.sv
module tb_cve2_csr_access_ctrl;
  localparam int NumReq = 2;
  localparam int NumCsr = 8;
  localparam int Width  = 32;
  localparam int IdxW   = 4;
`ifdef CVE2_CSR_ACCESS_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic                         clk, rst_n;
  logic [NumReq-1:0]            req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NumReq-1:0][1:0]       req_op;
  logic [NumReq-1:0][IdxW-1:0]  req_idx;
  logic [NumReq-1:0][Width-1:0] req_wdata;
  logic [Width-1:0]             rsp_rdata, csr_wr_data;
  logic                         rsp_err, alert;
  logic [NumCsr-1:0]            csr_wr_en, csr_rd_error, csr_lock;
  logic [NumCsr-1:0][Width-1:0] csr_rd_data;

  int vectors = 0;
  int miscompares = 0;

  cve2_csr_access_ctrl #(
    .NumReq (NumReq),
    .NumCsr (NumCsr),
    .Width  (Width),
    .IdxW   (IdxW)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_op_i          (req_op),
    .req_idx_i         (req_idx),
    .req_wdata_i       (req_wdata),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_rdata_o       (rsp_rdata),
    .rsp_err_o         (rsp_err),
    .csr_wr_en_o       (csr_wr_en),
    .csr_wr_data_o     (csr_wr_data),
    .csr_rd_data_i     (csr_rd_data),
    .csr_rd_error_i    (csr_rd_error),
    .csr_lock_i        (csr_lock),
    .integrity_alert_o (alert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CSR bank: single-cycle primitives updated on the write strobe.
  logic [Width-1:0] mem [NumCsr];
  logic             pre_en = 1'b0;
  logic [2:0]       pre_idx = '0;
  logic [Width-1:0] pre_val = '0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else for (int i = 0; i < NumCsr; i++) if (csr_wr_en[i]) mem[i] <= csr_wr_data;
  end
  always_comb for (int i = 0; i < NumCsr; i++) csr_rd_data[i] = mem[i];

  // Write-strobe monitor.
  int               wr_cnt = 0;
  int               idle_bad = 0;
  logic [NumCsr-1:0] wr_en_seen = '0;
  logic [Width-1:0] wr_data_seen = '0;
  always @(negedge clk) begin
    if (csr_wr_en != '0) begin
      wr_cnt       <= wr_cnt + 1;
      wr_en_seen   <= csr_wr_en;
      wr_data_seen <= csr_wr_data;
    end else if (csr_wr_data != '0) begin
      idle_bad <= idle_bad + 1;
    end
  end

  // Reference model state.
  logic [Width-1:0] model_mem [NumCsr];
  logic             model_alert = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [1:0] op, input logic [3:0] idx, input logic [31:0] wdata,
                            output logic [31:0] e_old, output logic e_err,
                            output logic e_wr, output logic [31:0] e_new);
    bit in_range;
    in_range = (idx < 4'(NumCsr));
    e_old = in_range ? model_mem[idx[2:0]] : 32'h0;
    e_err = !in_range || (csr_rd_error[idx[2:0]] === 1'b1) ||
            (LockEn && (csr_lock[idx[2:0]] === 1'b1) && op != 2'd0);
    case (op)
      2'd1:    e_new = wdata;
      2'd2:    e_new = e_old | wdata;
      2'd3:    e_new = e_old & ~wdata;
      default: e_new = e_old;
    endcase
    e_wr = !e_err && (op != 2'd0) && !((op >= 2'd2) && (wdata == 32'h0));
    if (e_wr) model_mem[idx[2:0]] = e_new;
    if (in_range && csr_rd_error[idx[2:0]] === 1'b1) model_alert = 1'b1;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pre_idx = 3'(idx); pre_val = val; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
    model_mem[idx] = val;
    @(negedge clk); #1;
  endtask

  task automatic access(input int r, input logic [1:0] op, input logic [3:0] idx,
                        input logic [31:0] wdata, input int hold);
    logic [31:0] e_old, e_new;
    logic        e_err, e_wr;
    int          n, lat, base;
    model_step(op, idx, wdata, e_old, e_err, e_wr, e_new);
    req_op[r] = op; req_idx[r] = idx; req_wdata[r] = wdata; req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (req_ready[r] !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    chk("req_ready", 32'(req_ready), 32'(1) << r);
    base = wr_cnt;
    @(negedge clk); req_valid[r] = 1'b0; #1;
    lat = 1;
    while (rsp_valid[r] !== 1'b1 && lat < 10) begin @(negedge clk); #1; lat++; end
    chk("rsp_valid", 32'(rsp_valid), 32'(1) << r);
    chk("latency", 32'(lat), e_wr ? 32'd3 : 32'd2);
    chk("rsp_rdata", rsp_rdata, e_old);
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("wr_count", 32'(wr_cnt - base), e_wr ? 32'd1 : 32'd0);
    if (e_wr) begin
      chk("wr_en", 32'(wr_en_seen), 32'(1) << idx);
      chk("wr_data", wr_data_seen, e_new);
    end
    chk("alert", 32'(alert), 32'(model_alert));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      chk("rsp_hold_valid", 32'(rsp_valid), 32'(1) << r);
      chk("rsp_hold_rdata", rsp_rdata, e_old);
    end
    rsp_ready[r] = 1'b1;
    @(negedge clk); rsp_ready[r] = 1'b0; #1;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  // Both requesters continuously valid; grants must alternate from requester 0.
  task automatic rr_run(input int n_acc);
    logic [31:0] e_old, e_new;
    logic        e_err, e_wr;
    int          g, n, lat, exp_g;
    exp_g = 0;
    for (int r = 0; r < NumReq; r++) begin
      req_op[r] = 2'($urandom_range(0, 3)); req_idx[r] = 4'($urandom_range(0, 7));
      req_wdata[r] = $urandom;
    end
    req_valid = '1;
    #1;
    for (int k = 0; k < n_acc; k++) begin
      n = 0;
      while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
      chk("rr_grant", 32'(req_ready), 32'(1) << exp_g);
      g = exp_g;
      model_step(req_op[g], req_idx[g], req_wdata[g], e_old, e_err, e_wr, e_new);
      @(negedge clk);
      req_op[g] = 2'($urandom_range(0, 3)); req_idx[g] = 4'($urandom_range(0, 7));
      req_wdata[g] = $urandom;
      #1;
      lat = 1;
      while (rsp_valid[g] !== 1'b1 && lat < 10) begin @(negedge clk); #1; lat++; end
      chk("rr_rsp_valid", 32'(rsp_valid), 32'(1) << g);
      chk("rr_rdata", rsp_rdata, e_old);
      chk("rr_err", 32'(rsp_err), 32'(e_err));
      rsp_ready[g] = 1'b1;
      @(negedge clk); rsp_ready[g] = 1'b0; #1;
      exp_g = 1 - exp_g;
    end
    req_valid = '0;
    @(negedge clk); #1;
  endtask

  initial begin
    int n;
    logic [31:0] m;
    logic [3:0]  ri;
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_idx = '0; req_wdata = '0;
    rsp_ready = '0; csr_rd_error = '0; csr_lock = '0;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < NumCsr; i++) preload(i, $urandom);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wr_en", 32'(csr_wr_en), 32'd0);
    chk("rst_alert", 32'(alert), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;

    rr_run(4);

    preload(3, 32'h0000_00F0);
    access(0, 2'd2, 4'd3, 32'h0000_000F, 0);
    chk("set_bank_value", mem[3], 32'h0000_00FF);

    preload(2, 32'h0000_A5A5);
    access(1, 2'd3, 4'd2, 32'h0, 0);

    access(0, 2'd1, 4'd9, 32'hDEAD_BEEF, 0);

    for (int t = 0; t < 40; t++) begin
      ri = 4'($urandom_range(0, 9));
      m = $urandom;
      if (ri < 4'(NumCsr)) m[ri[2:0]] = 1'b0;
      csr_rd_error = m[7:0];
      access($urandom_range(0, 1), 2'($urandom_range(0, 3)), ri,
             ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, 0);
    end
    csr_rd_error = '0;

    csr_rd_error = 8'h20;
    access(0, 2'd1, 4'd5, 32'h1111_2222, 0);
    csr_rd_error = '0;
    access(1, 2'd0, 4'd0, 32'h0, 0);

    csr_lock = 8'h02;
    access(1, 2'd1, 4'd1, 32'h0000_1234, 0);
    access(0, 2'd0, 4'd1, 32'h0, 0);
    csr_lock = '0;

    access(0, 2'd1, 4'd4, 32'h0000_CAFE, 5);

    req_op[0] = 2'd1; req_idx[0] = 4'd4; req_wdata[0] = 32'h5A5A_0000; req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    chk("rst_seq_accept", 32'(req_ready), 32'd1);
    @(negedge clk); req_valid[0] = 1'b0;
    @(negedge clk); #1;
    chk("rst_seq_wr_en", 32'(csr_wr_en), 32'h10);
    rst_n = 1'b0; #1;
    model_alert = 1'b0;
    chk("midrst_wr_en", 32'(csr_wr_en), 32'd0);
    chk("midrst_wr_data", csr_wr_data, 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    chk("midrst_err", 32'(rsp_err), 32'd0);
    chk("midrst_alert", 32'(alert), 32'd0);
    @(negedge clk); @(negedge clk);
    chk("midrst_no_write", mem[4], model_mem[4]);
    rst_n = 1'b1; #1;

    rr_run(2);
    access(1, 2'd2, 4'd6, 32'h8000_0001, 0);
    chk("wr_data_idle_zero", 32'(idle_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
